sysarr_out_deskew: RTL and testbench
====================================

Name: sysarr_out_deskew

Overview:
Drain-side collector at the bottom edge of the N x N systolic array. It is the counterpart of the input-side row FIFO that feeds skewed operand rows into the array.
- Receives per-column partial-sum results, which arrive skewed by one cycle per column.
- Re-aligns each result row and buffers it in a small row FIFO.
- Presents whole rows to the writeback path over a valid/ready handshake.
- Tracks the row index within the current matrix tile.

Parameters:
N, 4, array dimension (columns per row, rows per tile)
WIDTH, 16, bits per element
DEPTH, 4, aligned-row buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
in_valid  in  N  per-column result valid from the array's bottom row; bit j = column j
in_data  in  N*WIDTH  column j at [WIDTH*j +: WIDTH]
clear  in  1  synchronous flush of delay lines, buffer, row counter and error flag
out_valid  out  1  buffer non-empty
out_ready  in  1  consumer accepts the head row
out_data  out  N*WIDTH  head row, column j at [WIDTH*j +: WIDTH]
out_row_idx  out  $clog2(N)  row index of the head row within the tile
out_last  out  1  head row is row N-1 of the tile
overflow  out  1  sticky: an aligned row was dropped because the buffer was full
err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (nRST low, async) and clear (sync, highest priority):
  - All delay-line stages are invalid and zero.
  - Buffer is empty; out_valid=0, out_data=0.
  - Row counter = 0; out_row_idx=0, out_last=0.
  - overflow=0, err=0.
- Skew model: for row r, column j's in_valid arrives exactly j cycles after column 0's.
- Deskew:
  - Column j passes through N-1-j register stages carrying {valid, data}. Column N-1 has zero stages.
  - All stages shift every cycle; there is no back-pressure into the array.
- Aligned event: all N aligned valids are high in the same cycle. This is a row write request.
- Partial alignment (some but not all aligned valids high) is a misalignment. The partial row is never written.
- Buffer:
  - DEPTH-entry circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH)+1 bits (wrap bit).
  - Full = pointers differ only in the MSB. Empty = pointers equal.
  - Show-ahead: out_data is the head entry combinationally from storage; it is 0 when empty.
  - Pop when out_valid && out_ready.
- Latency: column N-1 valid sampled on edge t → out_valid high after edge t+1, i.e. one registered write.
- Full handling:
  - Write while full with no pop in the same cycle → row dropped, overflow set (sticky until reset/clear).
  - Write while full with a pop in the same cycle → both occur; no drop.
  - Write while empty and no pop → out_valid rises the next cycle. There is no same-cycle bypass.
- Row counter:
  - Each buffer entry stores its row index and last bit, captured from a write-side counter.
  - The counter increments per accepted write and wraps N-1 → 0.
  - Dropped rows do not advance the counter.
- out_valid stays high until popped. Data is stable while out_valid && !out_ready.
- Width: data is passed through unmodified; no arithmetic on elements.

Optional Feature:
Macro SYSARR_DESKEW_ERR_EN.
- Defined: a partial alignment sets err (sticky until reset/clear). The partial row is discarded and the row counter is unchanged.
- Undefined: partial rows are silently discarded, err is tied to 0, and no detection logic is built.

Decomposition:
- Shared package sysarr_pkg holds:
  - constants N, WIDTH
  - typedef elem_t = logic [WIDTH-1:0]
  - typedef row_t = elem_t [N-1:0]
  - typedef row_idx_t = logic [$clog2(N)-1:0]
- One natural sub-module: sysarr_row_buf, the DEPTH-entry valid/ready circular buffer of {row_t, row_idx_t, last}. It is instanced once; the deskew delay lines stay in the top.

Test Plan:
- N=4, WIDTH=16. Drive row r=0 with values 0x0010..0x0013, column j valid at cycle 5+j, out_ready=1. → out_valid at cycle 9 with out_data={0x0013,0x0012,0x0011,0x0010}, out_row_idx=0, out_last=0, for exactly one cycle.
- Four back-to-back skewed rows, out_ready=1. → four consecutive out_valid cycles with out_row_idx 0,1,2,3; out_last=1 only on idx 3; the fifth row's idx wraps to 0.
- out_ready=0, push 5 rows (DEPTH=4). → after the 4th row out_valid stays 1 with row 0 stable; the 5th row is dropped and overflow=1. Then with out_ready=1, rows 0..3 drain in order and overflow stays 1.
- Full buffer, with out_ready=1 in the same cycle as a 5th aligned row. → no drop, overflow=0, and the 5th row is delivered after rows 1..3.
- Column 2 valid one cycle late for one row (SYSARR_DESKEW_ERR_EN defined). → err=1, no row written, row counter unchanged. Same stimulus without the macro → err=0, no row written.
- Assert nRST low mid-drain with 2 rows buffered. → out_valid=0, out_data=0, overflow=0, err=0 immediately. A subsequent clean row reports out_row_idx=0.

Source files
------------

// File: rtl/sysarr_pkg.sv
// Shared types and constants for the systolic array edge logic (array size, element width, row payloads).
package sysarr_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef logic [WIDTH-1:0] elem_t;
  typedef elem_t [N-1:0]    row_t;
  typedef logic [IDX_W-1:0] row_idx_t;

  typedef struct packed {
    row_t     row;
    row_idx_t idx;
    logic     last;
  } buf_entry_t;

  localparam row_idx_t LAST_IDX = row_idx_t'(N - 1);

  // Row index within a tile, wrapping after the last row.
  function automatic row_idx_t next_row_idx(input row_idx_t idx);
    return (idx == LAST_IDX) ? '0 : idx + row_idx_t'(1);
  endfunction

endpackage

// File: rtl/sysarr_row_buf.sv
// Show-ahead circular buffer of aligned result rows with valid/ready read side and sticky drop flag.
module sysarr_row_buf
  import sysarr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       clear,
  input  logic       wr_en,
  input  buf_entry_t wr_entry,
  input  logic       rd_ready,
  output logic       rd_valid,
  output buf_entry_t rd_entry,
  output logic       wr_accept_c,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           overflow_q, overflow_d;
  buf_entry_t     mem_q [DEPTH];
  buf_entry_t     mem_d [DEPTH];

  logic empty_c, full_c, pop_c;

  assign empty_c     = (wr_ptr_q == rd_ptr_q);
  assign full_c      = (wr_ptr_q == {~rd_ptr_q[PTR_W], rd_ptr_q[PTR_W-1:0]});
  assign pop_c       = !clear && !empty_c && rd_ready;
  // A pop frees the head slot in the same cycle, so a full buffer can still take a row.
  assign wr_accept_c = !clear && wr_en && (!full_c || pop_c);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
      if (wr_accept_c) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = wr_entry;
        wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
      end else if (wr_en) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_valid = !empty_c;
  assign rd_entry = empty_c ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign overflow = overflow_q;

endmodule

// File: rtl/sysarr_out_deskew.sv
// Drain-side collector: deskews per-column results into whole rows and buffers them for writeback.
// Optional misalignment detection is built when SYSARR_DESKEW_ERR_EN is defined.
module sysarr_out_deskew
  import sysarr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]     out_row_idx,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 err
);

  logic [N-1:0] al_valid_c;
  row_t         al_row_c;

  // Column j is delayed N-1-j cycles so every column of a row lines up with the last column.
  for (genvar j = 0; j < int'(N); j++) begin : g_col
    localparam int unsigned STG = N - 1 - j;
    if (STG == 0) begin : g_pass
      assign al_valid_c[j] = in_valid[j];
      assign al_row_c[j]   = in_data[WIDTH*j +: WIDTH];
    end else begin : g_dly
      logic [STG-1:0] vld_q, vld_d;
      elem_t          dat_q [STG];
      elem_t          dat_d [STG];

      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clear) begin
          vld_d = '0;
          for (int k = 0; k < int'(STG); k++) begin
            dat_d[k] = '0;
          end
        end else begin
          vld_d[0] = in_valid[j];
          dat_d[0] = in_data[WIDTH*j +: WIDTH];
          for (int k = 1; k < int'(STG); k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
          vld_q <= '0;
          for (int k = 0; k < int'(STG); k++) begin
            dat_q[k] <= '0;
          end
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign al_valid_c[j] = vld_q[STG-1];
      assign al_row_c[j]   = dat_q[STG-1];
    end
  end

  logic       row_wr_c;
  logic       wr_accept_c;
  row_idx_t   row_cnt_q, row_cnt_d;
  buf_entry_t wr_entry_c;
  buf_entry_t rd_entry_c;

  assign row_wr_c   = &al_valid_c;
  assign wr_entry_c = '{row: al_row_c, idx: row_cnt_q, last: (row_cnt_q == LAST_IDX)};

  // Write-side row counter; dropped or partial rows leave it untouched.
  always_comb begin
    row_cnt_d = row_cnt_q;
    if (clear) begin
      row_cnt_d = '0;
    end else if (wr_accept_c) begin
      row_cnt_d = next_row_idx(row_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      row_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
    end
  end

  sysarr_row_buf #(
    .DEPTH (DEPTH)
  ) u_row_buf (
    .clk         (clk),
    .nRST        (nRST),
    .clear       (clear),
    .wr_en       (row_wr_c),
    .wr_entry    (wr_entry_c),
    .rd_ready    (out_ready),
    .rd_valid    (out_valid),
    .rd_entry    (rd_entry_c),
    .wr_accept_c (wr_accept_c),
    .overflow    (overflow)
  );

  assign out_data    = rd_entry_c.row;
  assign out_row_idx = rd_entry_c.idx;
  assign out_last    = rd_entry_c.last;

`ifdef SYSARR_DESKEW_ERR_EN
  logic partial_c;
  logic err_q, err_d;

  assign partial_c = (|al_valid_c) && !row_wr_c;

  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (partial_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sysarr_out_deskew.sv
// Directed bench for sysarr_out_deskew: schedule-driven skewed rows checked against a row-level model.
module tb_sysarr_out_deskew;
  import sysarr_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int MAXE  = 160;
  localparam int END_E = 150;
  localparam int NI    = int'(N);
  localparam int DW    = int'(N * WIDTH);
`ifdef SYSARR_DESKEW_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               nRST;
  logic [N-1:0]       in_valid;
  logic [DW-1:0]      in_data;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDX_W-1:0]   out_row_idx;
  logic               out_last;
  logic               overflow;
  logic               err;

  sysarr_out_deskew #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .overflow    (overflow),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Per-edge stimulus schedule
  logic [N-1:0]  s_valid [MAXE];
  logic [DW-1:0] s_data  [MAXE];
  logic          s_clear [MAXE];
  logic          s_ready [MAXE];
  logic          s_rstn  [MAXE];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge_cnt %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic add_row(input int start, input int base, input int late_col);
    for (int j = 0; j < NI; j++) begin
      int c;
      c = start + j + ((j == late_col) ? 1 : 0);
      s_valid[c][j] = 1'b1;
      s_data[c][WIDTH*j +: WIDTH] = WIDTH'(base + j);
    end
  endtask

  task automatic apply(input int e);
    in_valid  = s_valid[e];
    in_data   = s_data[e];
    clear     = s_clear[e];
    out_ready = s_ready[e];
    nRST      = s_rstn[e];
  endtask

  // Row-level model: column j of a row is sampled N-1-j edges before the row completes.
  typedef struct {
    logic [DW-1:0] d;
    int            idx;
    bit            last;
  } mrow_t;

  mrow_t         mq[$];
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  bit            m_err = 1'b0;
  int            clr_edge = 0;
  logic [N-1:0]  hv [MAXE];
  logic [DW-1:0] hd [MAXE];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_err    = 1'b0;
      clr_edge = edge_cnt;
    end else begin
      hv[edge_cnt] = in_valid;
      hd[edge_cnt] = in_data;
      if (clear) begin
        mq.delete();
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        clr_edge = edge_cnt;
      end else begin
        int            na;
        int            src;
        logic [DW-1:0] row;
        bit            pop;
        bit            full;
        bit            acc;
        na  = 0;
        row = '0;
        for (int j = 0; j < NI; j++) begin
          src = edge_cnt - (NI - 1 - j);
          if (src > clr_edge && hv[src][j]) begin
            na++;
            row[WIDTH*j +: WIDTH] = hd[src][WIDTH*j +: WIDTH];
          end
        end
        pop  = (mq.size() > 0) && out_ready;
        full = (mq.size() == int'(DEPTH));
        acc  = 1'b0;
        if (na == NI) begin
          if (full && !pop) m_ovf = 1'b1;
          else acc = 1'b1;
        end else if (na > 0 && ERR_ON) begin
          m_err = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{d: row, idx: m_cnt, last: (m_cnt == NI - 1)});
          m_cnt = (m_cnt + 1) % NI;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, plus hand-computed pins at chosen edges.
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      logic [DW-1:0] ed;
      int            ei;
      bit            el;
      ed = '0;
      ei = 0;
      el = 1'b0;
      if (mq.size() > 0) begin
        ed = mq[0].d;
        ei = mq[0].idx;
        el = mq[0].last;
      end
      chk("model out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("model out_data", 64'(out_data), 64'(ed));
      chk("model out_row_idx", 64'(out_row_idx), 64'(ei));
      chk("model out_last", 64'(out_last), 64'(el));
      chk("model overflow", 64'(overflow), 64'(m_ovf));
      chk("model err", 64'(err), 64'(m_err));

      case (edge_cnt)
        1: begin
          chk("reset out_valid", 64'(out_valid), 64'd0);
          chk("reset out_data", 64'(out_data), 64'd0);
          chk("reset out_row_idx", 64'(out_row_idx), 64'd0);
          chk("reset out_last", 64'(out_last), 64'd0);
          chk("reset overflow", 64'(overflow), 64'd0);
          chk("reset err", 64'(err), 64'd0);
        end
        13: chk("row0 not early", 64'(out_valid), 64'd0);
        14: begin
          chk("row0 out_valid", 64'(out_valid), 64'd1);
          chk("row0 out_data", 64'(out_data), 64'h0013_0012_0011_0010);
          chk("row0 out_row_idx", 64'(out_row_idx), 64'd0);
          chk("row0 out_last", 64'(out_last), 64'd0);
        end
        15: chk("row0 one cycle", 64'(out_valid), 64'd0);
        26: begin
          chk("b2b idx2", 64'(out_row_idx), 64'd2);
          chk("b2b idx2 last", 64'(out_last), 64'd0);
        end
        27: begin
          chk("b2b idx3", 64'(out_row_idx), 64'd3);
          chk("b2b idx3 last", 64'(out_last), 64'd1);
        end
        28: begin
          chk("b2b wrap idx", 64'(out_row_idx), 64'd0);
          chk("b2b wrap last", 64'(out_last), 64'd0);
          chk("b2b wrap data", 64'(out_data), 64'h0143_0142_0141_0140);
        end
        55: begin
          chk("full hold valid", 64'(out_valid), 64'd1);
          chk("full hold data", 64'(out_data), 64'h0203_0202_0201_0200);
          chk("full hold idx", 64'(out_row_idx), 64'd0);
          chk("drop overflow", 64'(overflow), 64'd1);
        end
        57: chk("drain idx1", 64'(out_row_idx), 64'd1);
        60: begin
          chk("drained valid", 64'(out_valid), 64'd0);
          chk("overflow sticky", 64'(overflow), 64'd1);
        end
        84: begin
          chk("full+pop valid", 64'(out_valid), 64'd1);
          chk("full+pop head idx", 64'(out_row_idx), 64'd1);
          chk("full+pop overflow", 64'(overflow), 64'd0);
        end
        89: begin
          chk("5th row idx", 64'(out_row_idx), 64'd0);
          chk("5th row data", 64'(out_data), 64'h0343_0342_0341_0340);
        end
        90: begin
          chk("5th drained", 64'(out_valid), 64'd0);
          chk("no drop overflow", 64'(overflow), 64'd0);
        end
        107: begin
          chk("partial no row", 64'(out_valid), 64'd0);
          chk("partial err", 64'(err), 64'(ERR_ON));
        end
        114: begin
          chk("after partial valid", 64'(out_valid), 64'd1);
          chk("after partial idx", 64'(out_row_idx), 64'd0);
          chk("after partial data", 64'(out_data), 64'h0503_0502_0501_0500);
        end
        134: begin
          chk("pre-reset valid", 64'(out_valid), 64'd1);
          chk("pre-reset idx", 64'(out_row_idx), 64'd2);
          chk("pre-reset overflow", 64'(overflow), 64'd1);
        end
        144: begin
          chk("post-reset valid", 64'(out_valid), 64'd1);
          chk("post-reset idx", 64'(out_row_idx), 64'd0);
          chk("post-reset data", 64'(out_data), 64'h0703_0702_0701_0700);
        end
        default: ;
      endcase
    end
  end

  initial begin
    for (int e = 0; e < MAXE; e++) begin
      s_valid[e] = '0;
      s_data[e]  = '0;
      s_clear[e] = 1'b0;
      s_ready[e] = 1'b1;
      s_rstn[e]  = 1'b1;
      hv[e]      = '0;
      hd[e]      = '0;
    end
    for (int e = 0; e <= 2; e++) s_rstn[e] = 1'b0;

    // single row
    add_row(10, 'h10, -1);
    // back-to-back rows with tile wrap
    s_clear[18] = 1'b1;
    for (int r = 0; r < 5; r++) add_row(20 + r, 'h100 + 'h10 * r, -1);
    // fill with no consumer, fifth row dropped
    s_clear[40] = 1'b1;
    for (int e = 40; e <= 55; e++) s_ready[e] = 1'b0;
    for (int r = 0; r < 5; r++) add_row(42 + r, 'h200 + 'h10 * r, -1);
    // full buffer, pop coincides with fifth write
    s_clear[70] = 1'b1;
    for (int e = 70; e <= 85; e++) s_ready[e] = 1'b0;
    s_ready[83] = 1'b1;
    for (int r = 0; r < 4; r++) add_row(72 + r, 'h300 + 'h10 * r, -1);
    add_row(80, 'h340, -1);
    // column 2 late by one cycle, then a clean row
    s_clear[100] = 1'b1;
    add_row(102, 'h400, 2);
    add_row(110, 'h500, -1);
    // async reset with two rows buffered
    s_clear[120] = 1'b1;
    for (int e = 120; e <= 137; e++) s_ready[e] = 1'b0;
    s_ready[131] = 1'b1;
    s_ready[132] = 1'b1;
    for (int r = 0; r < 5; r++) add_row(122 + r, 'h600 + 'h10 * r, -1);
    for (int e = 135; e <= 137; e++) s_rstn[e] = 1'b0;
    add_row(140, 'h700, -1);

    apply(0);
    while (1) begin
      @(posedge clk);
      #1;
      if (edge_cnt >= END_E) break;
      apply(edge_cnt);
      if (edge_cnt == 135) begin
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset out_data", 64'(out_data), 64'd0);
        chk("async reset overflow", 64'(overflow), 64'd0);
        chk("async reset err", 64'(err), 64'd0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
